// File: rtl/adder_serial_nbit_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_t   : FSM state encoding (IDLE, RUN, DONE)
//   cnt_width : digit counter width for a given digit count, never below 1
package adder_serial_nbit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int DIGIT_DEF = 2;

  function automatic int ndig_of(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/adder_serial_nbit_if.sv
// Operation handshake and data bundle for adder_serial_nbit.
//   master : issues start/sub/a/b/c_in, observes busy/done/s/c_out/ovf
//   slave  : the adder itself
interface adder_serial_nbit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, s, c_out, ovf
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, s, c_out, ovf
  );
endinterface

// File: rtl/adder_serial_nbit_digit_adder.sv
// One digit of the serial adder: a DIGIT-bit ripple chain of 1-bit full adders.
//   x, y      : digit operands
//   c_in      : carry into bit 0
//   s         : digit sum
//   c_out     : carry out of the top bit
//   c_msb_in  : carry into the top bit (for signed overflow detection)
module full_adder_1bit (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             c_in,
  output logic [DIGIT-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);
  logic [DIGIT:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder_1bit u_fa (
      .x     (x[i]),
      .y     (y[i]),
      .c_in  (c[i]),
      .s     (s[i]),
      .c_out (c[i+1])
    );
  end

  assign c_out    = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/adder_serial_nbit.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT RUN cycles
// per operation, start/busy/done handshake, registered s/c_out/ovf.
//   clk : system clock (rising edge)
//   rst : synchronous active-high reset
//   io  : adder_serial_nbit_if.slave (start, sub, a, b, c_in -> busy, done, s, c_out, ovf)
//
// state | meaning
// IDLE  | waiting for start; results hold
// RUN   | one digit added per cycle, NDIG cycles
// DONE  | done pulse; start here begins the next operation immediately
module adder_serial_nbit
  import adder_serial_nbit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input logic               clk,
  input logic               rst,
  adder_serial_nbit_if.slave io
);
  localparam int NDIG  = ndig_of(WIDTH, DIGIT);
  localparam int CNT_W = cnt_width(NDIG);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sr, b_sr, r_sr, r_nxt;
  logic [WIDTH+DIGIT-1:0] r_cat;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   s_q;
  logic               c_out_q, ovf_q;
  logic [DIGIT-1:0]   d_sum;
  logic               d_cout, d_cmsb;
  logic               accept, last;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x        (a_sr[DIGIT-1:0]),
    .y        (b_sr[DIGIT-1:0]),
    .c_in     (carry),
    .s        (d_sum),
    .c_out    (d_cout),
    .c_msb_in (d_cmsb)
  );

  // New digit enters at the top; the concatenation keeps DIGIT == WIDTH legal.
  assign r_cat = {d_sum, r_sr} >> DIGIT;
  assign r_nxt = r_cat[WIDTH-1:0];

  assign accept = io.start && (state != RUN);
  assign last   = (cnt == CNT_W'(NDIG - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.start) state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    state_nxt = io.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      carry   <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Subtraction is a + ~b + ~borrow, so the inversions happen once here.
        a_sr  <= io.a;
        b_sr  <= io.sub ? ~io.b : io.b;
        carry <= io.c_in ^ io.sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> DIGIT;
        b_sr  <= b_sr >> DIGIT;
        carry <= d_cout;
        r_sr  <= r_nxt;
        cnt   <= cnt + CNT_W'(1);
        if (last) begin
          s_q     <= r_nxt;
          c_out_q <= d_cout;
          ovf_q   <= d_cout ^ d_cmsb;
        end
      end
    end
  end

  assign io.busy  = (state == RUN);
  assign io.done  = (state == DONE);
  assign io.s     = s_q;
  assign io.c_out = c_out_q;
  assign io.ovf   = ovf_q;
endmodule

// File: tb/tb_adder_serial_nbit.sv
// Bench for adder_serial_nbit: table vectors and corner sequences on a
// DIGIT=2 instance, then a random sweep on DIGIT=2, 1 and 8 instances in
// parallel. Expected results go into per-instance queues on start and are
// popped when done pulses; every non-done cycle checks that results hold.
module tb_adder_serial_nbit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_serial_nbit_if #(.WIDTH(8)) if2 ();
  adder_serial_nbit_if #(.WIDTH(8)) if1 ();
  adder_serial_nbit_if #(.WIDTH(8)) if8 ();

  adder_serial_nbit #(.WIDTH(8), .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .io(if2));
  adder_serial_nbit #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .io(if1));
  adder_serial_nbit #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .io(if8));

  // res = {ovf, c_out, s}
  typedef struct { logic [9:0] res; int due; } exp_t;
  typedef struct { logic sub; logic [7:0] a; logic [7:0] b; logic cin; logic [9:0] res; } vec_t;

  exp_t q2[$], q1[$], q8[$];
  exp_t e2, e1, e8;
  logic [9:0] last2 = '0, last1 = '0, last8 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] model(input logic sub, input logic [7:0] a, input logic [7:0] b,
                                       input logic cin);
    logic [7:0] bb;
    logic       cc;
    logic [8:0] full;
    logic       ovf;
    bb   = sub ? ~b : b;
    cc   = sub ? ~cin : cin;
    full = {1'b0, a} + {1'b0, bb} + {8'b0, cc};
    ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
    return {ovf, full[8], full[7:0]};
  endfunction

  task automatic mon_done(input string nm, input logic busy, input logic [9:0] res, input exp_t e);
    chk({nm, " result"}, 32'(res), 32'(e.res));
    chk({nm, " latency"}, cyc, e.due);
    chk({nm, " busy in done"}, 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (if2.done === 1'b1) begin
        if (q2.size() == 0) chk("d2 spurious done", 32'(if2.done), 32'd0);
        else begin
          e2 = q2.pop_front();
          mon_done("d2", if2.busy, {if2.ovf, if2.c_out, if2.s}, e2);
          last2 = e2.res;
        end
      end else chk("d2 hold", 32'({if2.ovf, if2.c_out, if2.s}), 32'(last2));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (if1.done === 1'b1) begin
        if (q1.size() == 0) chk("d1 spurious done", 32'(if1.done), 32'd0);
        else begin
          e1 = q1.pop_front();
          mon_done("d1", if1.busy, {if1.ovf, if1.c_out, if1.s}, e1);
          last1 = e1.res;
        end
      end else chk("d1 hold", 32'({if1.ovf, if1.c_out, if1.s}), 32'(last1));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (if8.done === 1'b1) begin
        if (q8.size() == 0) chk("d8 spurious done", 32'(if8.done), 32'd0);
        else begin
          e8 = q8.pop_front();
          mon_done("d8", if8.busy, {if8.ovf, if8.c_out, if8.s}, e8);
          last8 = e8.res;
        end
      end else chk("d8 hold", 32'({if8.ovf, if8.c_out, if8.s}), 32'(last8));
    end
  end

  // One-cycle start pulse on the DIGIT=2 instance; returns right after start drops.
  task automatic go2(input logic sub, input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [9:0] res);
    @(posedge clk); #2;
    if2.start = 1'b1; if2.sub = sub; if2.a = a; if2.b = b; if2.c_in = cin;
    q2.push_back('{res: res, due: cyc + 1 + 4});
    @(posedge clk); #2;
    if2.start = 1'b0;
  endtask

  task automatic wait_all(input int budget);
    int n = 0;
    while ((q2.size() + q1.size() + q8.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done timeout", q2.size() + q1.size() + q8.size(), 0);
  endtask

  task automatic count_done2(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (if2.done === 1'b1) cnt++;
    end
  endtask

  vec_t tbl[10];
  int   cnt;
  logic [9:0] res;
  logic       r_sub, r_cin;
  logic [7:0] r_a, r_b;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00}};
    tbl[1] = '{1'b1, 8'h05, 8'h07, 1'b0, {1'b0, 1'b0, 8'hFE}};
    tbl[2] = '{1'b1, 8'h80, 8'h01, 1'b0, {1'b1, 1'b1, 8'h7F}};
    tbl[3] = '{1'b0, 8'h7F, 8'h00, 1'b1, {1'b1, 1'b0, 8'h80}};
    tbl[4] = '{1'b0, 8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00}};
    tbl[5] = '{1'b1, 8'h00, 8'h00, 1'b1, {1'b0, 1'b0, 8'hFF}};
    tbl[6] = '{1'b0, 8'h12, 8'h34, 1'b1, {1'b0, 1'b0, 8'h47}};
    tbl[7] = '{1'b1, 8'h7F, 8'hFF, 1'b0, {1'b1, 1'b0, 8'h80}};
    tbl[8] = '{1'b0, 8'h40, 8'h40, 1'b0, {1'b1, 1'b0, 8'h80}};
    tbl[9] = '{1'b1, 8'h00, 8'h01, 1'b0, {1'b0, 1'b0, 8'hFF}};

    if2.start = 0; if2.sub = 0; if2.a = 0; if2.b = 0; if2.c_in = 0;
    if1.start = 0; if1.sub = 0; if1.a = 0; if1.b = 0; if1.c_in = 0;
    if8.start = 0; if8.sub = 0; if8.a = 0; if8.b = 0; if8.c_in = 0;

    repeat (3) @(posedge clk);
    #2;
    chk("reset d2 busy/done", 32'({if2.busy, if2.done}), 32'd0);
    chk("reset d2 result", 32'({if2.ovf, if2.c_out, if2.s}), 32'd0);
    chk("reset d1 result", 32'({if1.busy, if1.done, if1.ovf, if1.c_out, if1.s}), 32'd0);
    chk("reset d8 result", 32'({if8.busy, if8.done, if8.ovf, if8.c_out, if8.s}), 32'd0);
    rst = 1'b0;

    // FF + 01: busy must be high for exactly NDIG = 4 cycles.
    go2(tbl[0].sub, tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].res);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if2.busy === 1'b1) cnt++;
    end
    chk("busy cycles", cnt, 4);
    wait_all(20);

    for (int i = 0; i < 10; i++) begin
      go2(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].res);
      wait_all(20);
      repeat (i % 3) @(posedge clk);
    end

    // Back-to-back: start held through DONE; second done 5 cycles after the first.
    @(posedge clk); #2;
    if2.start = 1'b1; if2.sub = 1'b0; if2.a = 8'h7F; if2.b = 8'h00; if2.c_in = 1'b1;
    q2.push_back('{res: {1'b1, 1'b0, 8'h80}, due: cyc + 1 + 4});
    @(posedge clk); #2;
    if2.sub = 1'b1; if2.a = 8'h80; if2.b = 8'h01; if2.c_in = 1'b0;
    q2.push_back('{res: {1'b1, 1'b1, 8'h7F}, due: cyc + 5 + 4});
    repeat (5) @(posedge clk);
    #2;
    if2.start = 1'b0;
    wait_all(20);

    // start pulsed two cycles into RUN with other operands is ignored.
    go2(1'b0, 8'h12, 8'h34, 1'b1, {1'b0, 1'b0, 8'h47});
    @(posedge clk); #2;
    if2.start = 1'b1; if2.sub = 1'b1; if2.a = 8'hFF; if2.b = 8'hFF; if2.c_in = 1'b0;
    @(posedge clk); #2;
    if2.start = 1'b0; if2.a = 8'hAA;
    wait_all(20);
    count_done2(8, cnt);
    chk("extra done after ignored start", cnt, 0);

    // Reset during the third RUN cycle discards the operation.
    go2(1'b0, 8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00});
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    q2.delete();
    last2 = '0; last1 = '0; last8 = '0;
    @(posedge clk); #2;
    chk("rst-in-run busy/done", 32'({if2.busy, if2.done}), 32'd0);
    chk("rst-in-run result", 32'({if2.ovf, if2.c_out, if2.s}), 32'd0);
    rst = 1'b0;
    count_done2(10, cnt);
    chk("done after reset", cnt, 0);
    go2(tbl[2].sub, tbl[2].a, tbl[2].b, tbl[2].cin, tbl[2].res);
    wait_all(20);

    // Random sweep on all three digit sizes.
    for (int n = 0; n < 1000; n++) begin
      r_sub = 1'($urandom);
      r_cin = 1'($urandom);
      r_a   = 8'($urandom);
      r_b   = 8'($urandom);
      res   = model(r_sub, r_a, r_b, r_cin);
      @(posedge clk); #2;
      if2.start = 1'b1; if2.sub = r_sub; if2.a = r_a; if2.b = r_b; if2.c_in = r_cin;
      if1.start = 1'b1; if1.sub = r_sub; if1.a = r_a; if1.b = r_b; if1.c_in = r_cin;
      if8.start = 1'b1; if8.sub = r_sub; if8.a = r_a; if8.b = r_b; if8.c_in = r_cin;
      q2.push_back('{res: res, due: cyc + 1 + 4});
      q1.push_back('{res: res, due: cyc + 1 + 8});
      q8.push_back('{res: res, due: cyc + 1 + 1});
      @(posedge clk); #2;
      if2.start = 1'b0; if1.start = 1'b0; if8.start = 1'b0;
      wait_all(20);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
